// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and its datapath (slave).
interface multicycle_control_fsm_if;
  logic [5:0] Op;
  logic       Zero;
  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [1:0] ALUOp;
  logic       IllegalOp;

  modport master (
    input  Op, Zero,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalOp
  );

  modport slave (
    output Op, Zero,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalOp
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main Moore control FSM of the multicycle MIPS core, with MEM_LAT wait cycles per memory state.
// Define BNE_EN to decode bne (000101) as a branch taken on ~Zero.
module multicycle_control_fsm #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t     state, next_state;
  logic [3:0] wait_cnt;
  logic       last;
  logic       mem_state;
  logic       pc_write;
  logic       branch;
  logic       branch_cond;

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign last      = (wait_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if (mem_state)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef BNE_EN
  logic is_bne;

  // Remembers whether the branch being executed is bne, so BRANCH needs no opcode decode.
  always_ff @(posedge clk) begin
    if (reset)
      is_bne <= 1'b0;
    else if (state == DECODE)
      is_bne <= (ctrl.Op == OP_BNE);
  end

  assign branch_cond = is_bne ? ~ctrl.Zero : ctrl.Zero;
`else
  assign branch_cond = ctrl.Zero;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      FETCH:  if (last) next_state = DECODE;
      DECODE: begin
        case (ctrl.Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
`ifdef BNE_EN
          OP_BNE:       next_state = BRANCH;
`endif
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (ctrl.Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (last) next_state = MEMWB;
      MEMWR:  if (last) next_state = FETCH;
      EXEC:   next_state = ALUWB;
      BRANCH: next_state = FETCH;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, ADDIWB, JUMP: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    ctrl.IorD      = 1'b0;
    ctrl.MemWrite  = 1'b0;
    ctrl.IRWrite   = 1'b0;
    ctrl.RegDst    = 1'b0;
    ctrl.MemtoReg  = 1'b0;
    ctrl.RegWrite  = 1'b0;
    ctrl.ALUSrcA   = 1'b0;
    ctrl.ALUSrcB   = 2'b00;
    ctrl.PCSrc     = 2'b00;
    ctrl.ALUOp     = 2'b00;
    ctrl.IllegalOp = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    unique case (state)
      FETCH: begin
        ctrl.ALUSrcB = 2'b01;
        ctrl.IRWrite = last;
        pc_write     = last;
      end
      DECODE: begin
        ctrl.ALUSrcB   = 2'b11;
        // DECODE only falls back to FETCH when the opcode was not recognised.
        ctrl.IllegalOp = (next_state == FETCH);
      end
      MEMADR, ADDIEX: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = 2'b10;
      end
      MEMRD: ctrl.IorD = 1'b1;
      MEMWB: begin
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      MEMWR: begin
        ctrl.IorD     = 1'b1;
        ctrl.MemWrite = last;
      end
      EXEC: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = 2'b10;
      end
      ALUWB: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      BRANCH: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = 2'b01;
        ctrl.PCSrc   = 2'b01;
        branch       = 1'b1;
      end
      ADDIWB: ctrl.RegWrite = 1'b1;
      JUMP: begin
        ctrl.PCSrc = 2'b10;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.PCEn = pc_write | (branch & branch_cond);

endmodule
